teller_dispatcher: RTL and testbench

//  Schedules the single-bank queue's customers onto up to N_TELLERS teller windows.
//  - Tracks each teller as closed, free, calling or serving.
//  - Uses round-robin to call the front customer to the next free, open teller.
//  - Issues a one-cycle dequeue pulse to the queue manager (front-sensor equivalent).
//  - Exports the open-teller count that indexes the wait-time LUT.

---
 rtl/teller_dispatcher_pkg.sv | 9 +
 rtl/teller_dispatcher_if.sv | 25 ++
 rtl/teller_dispatcher_rr_arbiter.sv | 24 ++
 rtl/teller_dispatcher.sv | 110 +++++++++++
 tb/tb_teller_dispatcher.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/teller_dispatcher_pkg.sv
// Shared types for the single-bank queue: teller/arbiter states and the index
// and count widths also used by the queue manager and the wait-time LUT.
package sbqm_pkg;
  localparam int T_IDX_W = 2;
  localparam int Q_CNT_W = 3;

  typedef enum logic [1:0] {CLOSED, FREE, CALLING, SERVING} teller_state_e;
  typedef enum logic [1:0] {IDLE, CALL, HOLD} arb_state_e;
endpackage

// File: rtl/teller_dispatcher_if.sv
// Dispatcher bus: queue-manager and teller-window signals around teller_dispatcher.
interface teller_dispatcher_if import sbqm_pkg::*; #(
  parameter int N_TELLERS = 3
) ();
  logic [Q_CNT_W-1:0]   q_count;
  logic [N_TELLERS-1:0] teller_open;
  logic [N_TELLERS-1:0] teller_done;
  logic [N_TELLERS-1:0] cust_arrived;
  logic                 dequeue;
  logic                 call_valid;
  logic [T_IDX_W-1:0]   call_teller;
  logic [N_TELLERS-1:0] busy;
  logic [T_IDX_W-1:0]   t_count;
  logic                 no_show;

  modport slave (
    input  q_count, teller_open, teller_done, cust_arrived,
    output dequeue, call_valid, call_teller, busy, t_count, no_show
  );

  modport master (
    output q_count, teller_open, teller_done, cust_arrived,
    input  dequeue, call_valid, call_teller, busy, t_count, no_show
  );
endinterface

// File: rtl/teller_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter import sbqm_pkg::*; #(
  parameter int N = 3
) (
  input  logic [N-1:0]       req,
  input  logic [T_IDX_W-1:0] ptr,
  output logic [T_IDX_W-1:0] grantIdx,
  output logic               grantValid
);
  logic [T_IDX_W-1:0] idx;

  always_comb begin
    grantIdx   = '0;
    grantValid = 1'b0;
    idx        = ptr;
    for (int k = 0; k < N; k++) begin
      idx = (idx == T_IDX_W'(N - 1)) ? '0 : idx + 1'b1;
      if (!grantValid && req[idx]) begin
        grantValid = 1'b1;
        grantIdx   = idx;
      end
    end
  end
endmodule

// File: rtl/teller_dispatcher.sv
// Calls the front customer of the bank queue to free, open teller windows in
// round-robin order; one call outstanding at a time.
module teller_dispatcher import sbqm_pkg::*; #(
  parameter int N_TELLERS    = 3,
  parameter int CALL_TIMEOUT = 15,
  parameter int HOLDOFF      = 2
) (
  input  logic               clk,
  input  logic               reset,
  teller_dispatcher_if.slave bus
);
  localparam int TMR_MAX = (CALL_TIMEOUT > HOLDOFF) ? CALL_TIMEOUT : HOLDOFF;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  arb_state_e           arbState, arbNext;
  logic [T_IDX_W-1:0]   rrPtr, winner, grantIdx, tCountR;
  logic [TMR_W-1:0]     timer;
  logic                 grantValid, doGrant, arrivedWin, timeout;
  logic                 dequeueR, noShowR;
  logic [N_TELLERS-1:0] eligible, busyNext, busyR;
  logic [T_IDX_W:0]     openCnt;

  rr_arbiter #(.N(N_TELLERS)) u_arb (
    .req       (eligible),
    .ptr       (rrPtr),
    .grantIdx  (grantIdx),
    .grantValid(grantValid)
  );

  assign doGrant    = (arbState == IDLE) && (bus.q_count != '0) && grantValid;
  assign arrivedWin = (arbState == CALL) && bus.cust_arrived[winner];
  // Arrival on the last call cycle beats the timeout.
  assign timeout    = (arbState == CALL) && (timer == TMR_W'(CALL_TIMEOUT - 1)) && !arrivedWin;

  for (genvar i = 0; i < N_TELLERS; i++) begin : g_teller
    teller_state_e st, nx;
    logic          grantMe;

    assign grantMe = doGrant && (grantIdx == T_IDX_W'(i));

    always_comb begin
      nx = st;
      unique case (st)
        CLOSED:  if (bus.teller_open[i]) nx = FREE;
        FREE:    if (!bus.teller_open[i]) nx = CLOSED;
                 else if (grantMe) nx = CALLING;
        CALLING: if (bus.cust_arrived[i]) nx = SERVING;
                 else if (timeout) nx = FREE;
        // A close request while busy is honoured only when service ends.
        SERVING: if (bus.teller_done[i]) nx = bus.teller_open[i] ? FREE : CLOSED;
        default: nx = FREE;
      endcase
    end

    always_ff @(posedge clk or posedge reset)
      if (reset) st <= FREE;
      else       st <= nx;

    assign eligible[i] = (st == FREE) && bus.teller_open[i];
    assign busyNext[i] = (nx == CALLING) || (nx == SERVING);
  end

  always_comb begin
    arbNext = arbState;
    unique case (arbState)
      IDLE:    if (doGrant) arbNext = CALL;
      CALL:    if (arrivedWin || timeout) arbNext = HOLD;
      HOLD:    if (timer == TMR_W'(HOLDOFF - 1)) arbNext = IDLE;
      default: arbNext = IDLE;
    endcase
  end

  always_comb begin
    openCnt = '0;
    for (int i = 0; i < N_TELLERS; i++)
      openCnt = openCnt + (T_IDX_W + 1)'(bus.teller_open[i]);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      arbState <= IDLE;
      rrPtr    <= T_IDX_W'(N_TELLERS - 1);
      winner   <= '0;
      timer    <= '0;
      dequeueR <= 1'b0;
      noShowR  <= 1'b0;
      busyR    <= '0;
      tCountR  <= '0;
    end else begin
      arbState <= arbNext;
      dequeueR <= arrivedWin || timeout;
      noShowR  <= timeout;
      busyR    <= busyNext;
      tCountR  <= (openCnt > (T_IDX_W + 1)'(3)) ? {T_IDX_W{1'b1}} : openCnt[T_IDX_W-1:0];
      if (doGrant) begin
        winner <= grantIdx;
        rrPtr  <= grantIdx;
      end
      // One timer serves both the call window and the post-dequeue holdoff.
      if (arbNext != arbState)  timer <= '0;
      else if (arbState != IDLE) timer <= timer + 1'b1;
    end

  assign bus.call_valid  = (arbState == CALL);
  assign bus.call_teller = (arbState == CALL) ? winner : '0;
  assign bus.dequeue     = dequeueR;
  assign bus.no_show     = noShowR;
  assign bus.busy        = busyR;
  assign bus.t_count     = tCountR;
endmodule

// File: tb/tb_teller_dispatcher.sv
// Scenario bench for teller_dispatcher against a call-level reference model.
module tb_teller_dispatcher;
  import sbqm_pkg::*;

  localparam int N  = 3;
  localparam int TO = 15;
  localparam int HO = 2;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  int           lastWin;
  logic [N-1:0] serving;

  teller_dispatcher_if #(.N_TELLERS(N)) bus ();

  teller_dispatcher #(.N_TELLERS(N), .CALL_TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic modelReset;
    lastWin = N - 1;
    serving = '0;
  endtask

  // Next open, non-busy teller after the previous winner, wrapping.
  function automatic int expWinner(input logic [N-1:0] open);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (lastWin + k) % N;
      if (open[i] && !serving[i]) return i;
    end
    return -1;
  endfunction

  task automatic waitCall(output int lat);
    lat = 0;
    while (!bus.call_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!bus.call_valid) begin
      vecs++; errs++;
      $display("FAIL wait_call: call_valid never rose within 60 cycles");
      lat = -1;
    end
  endtask

  // Entered on the first cycle with call_valid; arrival offered d cycles later.
  task automatic doCall(input int t, input int d);
    bit arrived;
    arrived = (d < TO);
    vecs++;
    if (bus.call_teller !== 2'(t)) begin
      errs++;
      $display("FAIL call_teller: got %0d want %0d", bus.call_teller, t);
    end
    for (int k = 0; k < TO; k++) begin
      vecs++;
      if (bus.call_valid !== 1'b1 || bus.no_show !== 1'b0 || bus.dequeue !== 1'b0) begin
        errs++;
        $display("FAIL call_window k=%0d: valid/no_show/dequeue=%b%b%b want 100",
                 k, bus.call_valid, bus.no_show, bus.dequeue);
      end
      if (k == d) begin
        bus.cust_arrived[t[1:0]] = 1'b1;
        break;
      end
      tick();
    end
    if (arrived) begin
      tick();
      bus.cust_arrived = '0;
      serving[t] = 1'b1;
    end
    lastWin = t;
    vecs++;
    if (bus.dequeue !== 1'b1 || bus.no_show !== !arrived || bus.call_valid !== 1'b0 ||
        bus.busy[t[1:0]] !== arrived) begin
      errs++;
      $display("FAIL call_end t=%0d d=%0d: dequeue=%b no_show=%b valid=%b busy=%b want 1 %b 0 %b",
               t, d, bus.dequeue, bus.no_show, bus.call_valid, bus.busy[t[1:0]], !arrived, arrived);
    end
    tick();
    vecs++;
    if (bus.dequeue !== 1'b0 || bus.no_show !== 1'b0) begin
      errs++;
      $display("FAIL pulse_width: dequeue=%b no_show=%b want 0 0", bus.dequeue, bus.no_show);
    end
  endtask

  task automatic releaseAll;
    bus.teller_done = serving;
    tick();
    bus.teller_done = '0;
    serving = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.q_count = '0; bus.teller_open = '0; bus.teller_done = '0; bus.cust_arrived = '0;
    modelReset();
    tick(); tick();
    vecs++;
    if ({bus.call_valid, bus.call_teller, bus.dequeue, bus.no_show, bus.busy, bus.t_count} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %b want all zero",
               {bus.call_valid, bus.call_teller, bus.dequeue, bus.no_show, bus.busy, bus.t_count});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    int lat;
    bus.teller_open = 3'b111;
    tick(); tick();
    bus.q_count = 3'd3;
    for (int c = 0; c < N; c++) begin
      waitCall(lat);
      vecs++;
      if (lat !== ((c == 0) ? 1 : HO)) begin
        errs++;
        $display("FAIL call_latency c=%0d: got %0d want %0d", c, lat, (c == 0) ? 1 : HO);
      end
      if (lat >= 0) doCall(expWinner(bus.teller_open), $urandom_range(0, 5));
    end
    bus.q_count = '0;
    releaseAll();
    vecs++;
    if (bus.busy !== '0) begin
      errs++;
      $display("FAIL busy_after_done: got %b want 000", bus.busy);
    end
  endtask

  task automatic test_no_show;
    int lat;
    bus.teller_open = 3'b110;
    tick(); tick();
    bus.q_count = 3'd1;
    waitCall(lat);
    vecs++;
    if (lat !== 1) begin errs++; $display("FAIL no_show_latency: got %0d want 1", lat); end
    if (lat >= 0) doCall(expWinner(bus.teller_open), TO + 3);
    bus.q_count = '0;
    bus.teller_open = 3'b111;
    tick(); tick(); tick();
  endtask

  task automatic test_arrival_at_timeout;
    int lat;
    bus.q_count = 3'd1;
    waitCall(lat);
    if (lat >= 0) doCall(expWinner(bus.teller_open), TO - 1);
    bus.q_count = '0;
    releaseAll();
  endtask

  task automatic test_partial_open;
    int lat, victim;
    logic [N-1:0] open;
    open = 3'b101;
    bus.teller_open = open;
    tick(); tick();
    vecs++;
    if (bus.t_count !== 2'($countones(open))) begin
      errs++;
      $display("FAIL t_count: got %0d want %0d", bus.t_count, $countones(open));
    end
    for (int c = 0; c < 4; c++) begin
      bus.q_count = 3'd2;
      waitCall(lat);
      if (lat >= 0) doCall(expWinner(open), $urandom_range(0, 10));
      bus.q_count = '0;
      releaseAll();
    end
    bus.q_count = 3'd1;
    victim = expWinner(open);
    waitCall(lat);
    if (lat >= 0) doCall(victim, 2);
    bus.q_count = '0;
    open[victim] = 1'b0;
    bus.teller_open = open;
    tick();
    releaseAll();
    vecs++;
    if (bus.busy !== '0) begin
      errs++;
      $display("FAIL close_while_serving busy: got %b want 000", bus.busy);
    end
    bus.q_count = 3'd1;
    waitCall(lat);
    vecs++;
    if (lat !== 1) begin errs++; $display("FAIL closed_skip_latency: got %0d want 1", lat); end
    if (lat >= 0) doCall(expWinner(open), 1);
    bus.q_count = '0;
    releaseAll();
  endtask

  task automatic test_idle;
    int lat, bad;
    bus.teller_open = 3'b111;
    tick(); tick();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bus.call_valid !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL idle_no_call: %0d cycles with call_valid, want 0", bad); end
    bus.q_count = 3'd1;
    waitCall(lat);
    vecs++;
    if (lat < 1 || lat > 2) begin errs++; $display("FAIL idle_wake_latency: got %0d want 1..2", lat); end
    if (lat >= 0) doCall(expWinner(bus.teller_open), $urandom_range(0, 6));
    bus.q_count = '0;
    releaseAll();
  endtask

  task automatic test_reset_mid_call;
    int lat;
    bus.teller_open = 3'b111;
    bus.q_count = 3'd1;
    waitCall(lat);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    vecs++;
    if ({bus.call_valid, bus.call_teller, bus.busy, bus.dequeue, bus.no_show} !== '0) begin
      errs++;
      $display("FAIL reset_mid_call: got %b want all zero",
               {bus.call_valid, bus.call_teller, bus.busy, bus.dequeue, bus.no_show});
    end
    modelReset();
    for (int c = 0; c < 3; c++) begin
      tick();
      vecs++;
      if (bus.dequeue !== 1'b0 || bus.no_show !== 1'b0 || bus.call_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold c=%0d: dequeue=%b no_show=%b valid=%b want 000",
                 c, bus.dequeue, bus.no_show, bus.call_valid);
      end
    end
    reset = 1'b0;
    waitCall(lat);
    vecs++;
    if (lat !== 1) begin errs++; $display("FAIL post_reset_latency: got %0d want 1", lat); end
    if (lat >= 0) doCall(expWinner(bus.teller_open), $urandom_range(0, 8));
    bus.q_count = '0;
    releaseAll();
  endtask

  task automatic test_random;
    int lat, exp, bad;
    logic [N-1:0] open, doneMask;
    for (int it = 0; it < 40; it++) begin
      bus.q_count = '0;
      doneMask = N'($urandom) & serving;
      bus.teller_done = doneMask;
      tick();
      bus.teller_done = '0;
      serving = serving & ~doneMask;
      open = N'($urandom_range(0, 7));
      bus.teller_open = open;
      tick(); tick(); tick();
      vecs++;
      if (bus.t_count !== 2'($countones(open)) || bus.busy !== serving) begin
        errs++;
        $display("FAIL rand_status it=%0d: t_count=%0d busy=%b want %0d %b",
                 it, bus.t_count, bus.busy, $countones(open), serving);
      end
      bus.q_count = 3'($urandom_range(1, 7));
      exp = expWinner(open);
      if (exp < 0) begin
        bad = 0;
        for (int c = 0; c < 6; c++) begin
          tick();
          if (bus.call_valid !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin errs++; $display("FAIL rand_no_eligible it=%0d: %0d call cycles want 0", it, bad); end
      end else begin
        waitCall(lat);
        vecs++;
        if (lat !== 1) begin errs++; $display("FAIL rand_latency it=%0d: got %0d want 1", it, lat); end
        if (lat >= 0) doCall(exp, $urandom_range(0, 18));
      end
    end
    bus.q_count = '0;
    releaseAll();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_no_show();
    test_arrival_at_timeout();
    test_partial_open();
    test_idle();
    test_reset_mid_call();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
